// File: rtl/lampfpu_sqrt_ctrl.sv
// rtl/lampfpu_sqrt_ctrl.sv - lampFPU sqrt/inv-sqrt sequencer; optional subnormal support via LAMP_SQRT_DENORM_EN
module lampfpu_sqrt_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        op_i,
    input  logic [15:0] op_a_i,
    output logic        ready_o,
    output logic        doSqrt_o,
    output logic        doInvSqrt_o,
    output logic [8:0]  f_o,
    input  logic [15:0] fract_res_i,
    input  logic        fract_valid_i,
    output logic [15:0] result_o,
    output logic        valid_o,
    output logic        invalid_o,
    output logic        divzero_o
);

    localparam logic [15:0]        QNAN    = 16'h7FC0;
    localparam logic [14:0]        INF_MAG = 15'h7F80;
    localparam logic signed [9:0]  BIAS    = 10'sd127;

    // Operand classes
    localparam logic [2:0] C_NORMAL = 3'd0;
    localparam logic [2:0] C_SUB    = 3'd1;
    localparam logic [2:0] C_ZERO   = 3'd2;
    localparam logic [2:0] C_NAN    = 3'd3;
    localparam logic [2:0] C_NEG    = 3'd4;
    localparam logic [2:0] C_PINF   = 3'd5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
`ifdef LAMP_SQRT_DENORM_EN
        NORM    = 3'd1,
`endif
        ISSUE   = 3'd2,
        WAIT    = 3'd3,
        POST    = 3'd4,
        SPECIAL = 3'd5
    } state_t;

    state_t state, state_n;

    logic              op_q, sign_q;
    logic [7:0]        exp_q;
    logic [6:0]        man_q;
    logic signed [9:0] k_q, k_n;
    logic [8:0]        f_n;
    logic [15:0]       fract_q;
    logic              ld_op, ld_f, cap, out_ld, inv_n, dz_n;
    logic [15:0]       res_n;
    logic signed [9:0] ue_in;

    logic [6:0]        pm;
    logic              pg, ps, p_ok;
    logic signed [9:0] pw, ek, cy;
    logic [7:0]        pm_r, pexp;
    logic [15:0]       post_res;

    // NaN wins over sign; without subnormal support any zero exponent counts as zero
    function automatic logic [2:0] classify(input logic s, input logic [7:0] e, input logic [6:0] m);
        logic [2:0] c;
        if (e == 8'hFF && m != 7'd0)
            c = C_NAN;
`ifdef LAMP_SQRT_DENORM_EN
        else if (e == 8'd0 && m == 7'd0)
`else
        else if (e == 8'd0)
`endif
            c = C_ZERO;
        else if (s)
            c = C_NEG;
        else if (e == 8'hFF)
            c = C_PINF;
        else if (e == 8'd0)
            c = C_SUB;
        else
            c = C_NORMAL;
        return c;
    endfunction

    // Even exponent scales the mantissa into [1/4,1/2), odd into [1/2,1); returns {k, f}
    function automatic logic [18:0] prep(input logic signed [9:0] ue, input logic [6:0] m);
        logic [8:0]        f;
        logic signed [9:0] k;
        if (ue[0] == 1'b0) begin
            f = {2'b01, m};
            k = (ue + 10'sd2) >>> 1;
        end else begin
            f = {1'b1, m, 1'b0};
            k = (ue + 10'sd1) >>> 1;
        end
        return {k, f};
    endfunction

    assign ue_in       = $signed({2'b00, op_a_i[14:7]}) - BIAS;
    assign ready_o     = (state == IDLE);
    assign doSqrt_o    = (state == ISSUE) && !op_q;
    assign doInvSqrt_o = (state == ISSUE) && op_q;

`ifdef LAMP_SQRT_DENORM_EN
    logic [2:0]        lz, sh;
    logic              lz_found;
    logic [6:0]        man_n;
    logic signed [9:0] ue_sub;

    // Leading-zero count moves the first set mantissa bit into the hidden position
    always_comb begin
        lz       = 3'd0;
        lz_found = 1'b0;
        for (int i = 6; i >= 0; i--) begin
            if (!lz_found) begin
                if (man_q[i])
                    lz_found = 1'b1;
                else
                    lz = lz + 3'd1;
            end
        end
        sh     = lz + 3'd1;
        man_n  = man_q << sh;
        ue_sub = -10'sd126 - $signed({7'd0, sh});
    end
`endif

    // Normalise, round to nearest even and pack the captured core result
    always_comb begin
        pm   = 7'd0;
        pg   = 1'b0;
        ps   = 1'b0;
        pw   = 10'sd0;
        p_ok = 1'b1;
        if (fract_q[15]) begin
            pm = fract_q[14:8]; pg = fract_q[7]; ps = |fract_q[6:0]; pw = 10'sd1;
        end else if (fract_q[14]) begin
            pm = fract_q[13:7]; pg = fract_q[6]; ps = |fract_q[5:0]; pw = 10'sd0;
        end else if (fract_q[13]) begin
            pm = fract_q[12:6]; pg = fract_q[5]; ps = |fract_q[4:0]; pw = -10'sd1;
        end else begin
            p_ok = 1'b0;
        end
        pm_r     = {1'b0, pm} + {7'd0, pg & (ps | pm[0])};
        ek       = op_q ? -k_q : k_q;
        cy       = $signed({9'd0, pm_r[7]});
        pexp     = 8'(BIAS + ek + pw + cy);
        post_res = p_ok ? {1'b0, pexp, pm_r[6:0]} : QNAN;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Next-state and datapath control
    always_comb begin
        state_n = state;
        ld_op   = 1'b0;
        ld_f    = 1'b0;
        f_n     = f_o;
        k_n     = k_q;
        cap     = 1'b0;
        out_ld  = 1'b0;
        res_n   = result_o;
        inv_n   = 1'b0;
        dz_n    = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    ld_op = 1'b1;
                    case (classify(op_a_i[15], op_a_i[14:7], op_a_i[6:0]))
                        C_NORMAL: begin
                            state_n    = ISSUE;
                            ld_f       = 1'b1;
                            {k_n, f_n} = prep(ue_in, op_a_i[6:0]);
                        end
`ifdef LAMP_SQRT_DENORM_EN
                        C_SUB:   state_n = NORM;
`endif
                        default: state_n = SPECIAL;
                    endcase
                end
            end
`ifdef LAMP_SQRT_DENORM_EN
            NORM: begin
                state_n    = ISSUE;
                ld_f       = 1'b1;
                {k_n, f_n} = prep(ue_sub, man_n);
            end
`endif
            ISSUE: state_n = WAIT;
            WAIT: begin
                if (fract_valid_i) begin
                    cap     = 1'b1;
                    state_n = POST;
                end
            end
            POST: begin
                out_ld  = 1'b1;
                res_n   = post_res;
                inv_n   = !p_ok;
                state_n = IDLE;
            end
            SPECIAL: begin
                out_ld  = 1'b1;
                state_n = IDLE;
                case (classify(sign_q, exp_q, man_q))
                    C_NEG: begin
                        res_n = QNAN;
                        inv_n = 1'b1;
                    end
                    C_ZERO: begin
                        if (op_q) begin
                            res_n = {sign_q, INF_MAG};
                            dz_n  = 1'b1;
                        end else begin
                            res_n = {sign_q, 15'd0};
                        end
                    end
                    C_PINF:  res_n = op_q ? 16'h0000 : {1'b0, INF_MAG};
                    default: res_n = QNAN;
                endcase
            end
            default: state_n = IDLE;
        endcase
    end

    // Operand, core-input, capture and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= 1'b0;
            sign_q    <= 1'b0;
            exp_q     <= 8'd0;
            man_q     <= 7'd0;
            k_q       <= 10'sd0;
            f_o       <= 9'd0;
            fract_q   <= 16'd0;
            result_o  <= 16'd0;
            valid_o   <= 1'b0;
            invalid_o <= 1'b0;
            divzero_o <= 1'b0;
        end else begin
            if (ld_op) begin
                op_q   <= op_i;
                sign_q <= op_a_i[15];
                exp_q  <= op_a_i[14:7];
                man_q  <= op_a_i[6:0];
            end
            if (ld_f) begin
                f_o <= f_n;
                k_q <= k_n;
            end
            if (cap)
                fract_q <= fract_res_i;
            if (out_ld)
                result_o <= res_n;
            valid_o   <= out_ld;
            invalid_o <= out_ld & inv_n;
            divzero_o <= out_ld & dz_n;
        end
    end

endmodule

// File: tb/tb_lampfpu_sqrt_ctrl.sv
// tb/tb_lampfpu_sqrt_ctrl.sv - directed vector bench for lampfpu_sqrt_ctrl
module tb_lampfpu_sqrt_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        op_i = 1'b0;
    logic [15:0] op_a_i = 16'h0;
    logic        ready_o, doSqrt_o, doInvSqrt_o;
    logic [8:0]  f_o;
    logic [15:0] fract_res_i = 16'hDEAD;
    logic        fract_valid_i = 1'b0;
    logic [15:0] result_o;
    logic        valid_o, invalid_o, divzero_o;

    int n_tests = 0;
    int n_fail  = 0;

    lampfpu_sqrt_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .op_i          (op_i),
        .op_a_i        (op_a_i),
        .ready_o       (ready_o),
        .doSqrt_o      (doSqrt_o),
        .doInvSqrt_o   (doInvSqrt_o),
        .f_o           (f_o),
        .fract_res_i   (fract_res_i),
        .fract_valid_i (fract_valid_i),
        .result_o      (result_o),
        .valid_o       (valid_o),
        .invalid_o     (invalid_o),
        .divzero_o     (divzero_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        op;
        logic [15:0] a;
        logic        launch;
        int          lat;
        logic [8:0]  f;
        logic [15:0] core;
        logic [15:0] res;
        logic        inv;
        logic        dz;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input logic op, input logic [15:0] a,
                                input logic launch, input int lat, input logic [8:0] f,
                                input logic [15:0] core, input logic [15:0] res,
                                input logic inv, input logic dz);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.launch = launch; v.lat = lat;
        v.f = f; v.core = core; v.res = res; v.inv = inv; v.dz = dz;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        bit seen;
        @(negedge clk);
        chk({v.name, " ready"}, ready_o, 1);
        start_i = 1'b1; op_i = v.op; op_a_i = v.a;
        @(negedge clk);
        start_i = 1'b0; op_a_i = 16'h0;
        if (v.launch) begin
            cyc = 1; seen = 0;
            while (!seen && cyc <= 4) begin
                if (doSqrt_o || doInvSqrt_o) seen = 1;
                else begin
                    @(negedge clk);
                    cyc++;
                end
            end
            chk({v.name, " launch_lat"}, seen ? cyc : 0, v.lat);
            if (!seen) return;
            chk({v.name, " launch_kind"}, {doSqrt_o, doInvSqrt_o}, v.op ? 2'b01 : 2'b10);
            chk({v.name, " f_o"}, f_o, v.f);
            @(negedge clk);
            chk({v.name, " launch_1cyc"}, doSqrt_o | doInvSqrt_o, 0);
            @(negedge clk);
            fract_valid_i = 1'b1; fract_res_i = v.core;
            @(negedge clk);
            fract_valid_i = 1'b0; fract_res_i = 16'hDEAD;
            chk({v.name, " valid_early"}, valid_o, 0);
        end else begin
            chk({v.name, " no_launch"}, doSqrt_o | doInvSqrt_o, 0);
            chk({v.name, " valid_early"}, valid_o, 0);
        end
        @(negedge clk);
        chk({v.name, " valid"}, valid_o, 1);
        chk({v.name, " result"}, result_o, v.res);
        chk({v.name, " invalid"}, invalid_o, v.inv);
        chk({v.name, " divzero"}, divzero_o, v.dz);
        chk({v.name, " ready_in_valid"}, ready_o, 1);
        @(negedge clk);
        chk({v.name, " valid_1cyc"}, valid_o, 0);
        chk({v.name, " result_hold"}, result_o, v.res);
        chk({v.name, " flags_unq"}, {invalid_o, divzero_o}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, launches;
        bit got, fed, bad;

        vecs.push_back(mk("sqrt4",      0, 16'h4080, 1, 1, 9'h080, 16'h2000, 16'h4000, 0, 0));
        vecs.push_back(mk("isqrt4",     1, 16'h4080, 1, 1, 9'h080, 16'h8000, 16'h3F00, 0, 0));
        vecs.push_back(mk("sqrt2",      0, 16'h4000, 1, 1, 9'h100, 16'h2D41, 16'h3FB5, 0, 0));
        vecs.push_back(mk("isqrt2",     1, 16'h4000, 1, 1, 9'h100, 16'h5A82, 16'h3F35, 0, 0));
        vecs.push_back(mk("sqrt_q",     0, 16'h3E80, 1, 1, 9'h080, 16'h2000, 16'h3F00, 0, 0));
        vecs.push_back(mk("sqrt_h",     0, 16'h3F00, 1, 1, 9'h100, 16'h2D41, 16'h3F35, 0, 0));
        vecs.push_back(mk("isqrt_h",    1, 16'h3F00, 1, 1, 9'h100, 16'h5A82, 16'h3FB5, 0, 0));
        vecs.push_back(mk("tie_dn",     0, 16'h4080, 1, 1, 9'h080, 16'h2020, 16'h4000, 0, 0));
        vecs.push_back(mk("tie_up",     0, 16'h4080, 1, 1, 9'h080, 16'h2060, 16'h4002, 0, 0));
        vecs.push_back(mk("sticky_up",  0, 16'h4080, 1, 1, 9'h080, 16'h2021, 16'h4001, 0, 0));
        vecs.push_back(mk("carry",      0, 16'h4080, 1, 1, 9'h080, 16'h3FE0, 16'h4080, 0, 0));
        vecs.push_back(mk("no_lead",    0, 16'h4080, 1, 1, 9'h080, 16'h1000, 16'h7FC0, 1, 0));
        vecs.push_back(mk("neg_one",    0, 16'hBF80, 0, 0, 9'h000, 16'h0000, 16'h7FC0, 1, 0));
        vecs.push_back(mk("neg_inf",    0, 16'hFF80, 0, 0, 9'h000, 16'h0000, 16'h7FC0, 1, 0));
        vecs.push_back(mk("isq_neginf", 1, 16'hFF80, 0, 0, 9'h000, 16'h0000, 16'h7FC0, 1, 0));
        vecs.push_back(mk("nan",        0, 16'h7FC1, 0, 0, 9'h000, 16'h0000, 16'h7FC0, 0, 0));
        vecs.push_back(mk("neg_nan",    1, 16'hFFC1, 0, 0, 9'h000, 16'h0000, 16'h7FC0, 0, 0));
        vecs.push_back(mk("isq_zero",   1, 16'h0000, 0, 0, 9'h000, 16'h0000, 16'h7F80, 0, 1));
        vecs.push_back(mk("isq_nzero",  1, 16'h8000, 0, 0, 9'h000, 16'h0000, 16'hFF80, 0, 1));
        vecs.push_back(mk("sqrt_zero",  0, 16'h0000, 0, 0, 9'h000, 16'h0000, 16'h0000, 0, 0));
        vecs.push_back(mk("sqrt_nzero", 0, 16'h8000, 0, 0, 9'h000, 16'h0000, 16'h8000, 0, 0));
        vecs.push_back(mk("sqrt_inf",   0, 16'h7F80, 0, 0, 9'h000, 16'h0000, 16'h7F80, 0, 0));
        vecs.push_back(mk("isq_inf",    1, 16'h7F80, 0, 0, 9'h000, 16'h0000, 16'h0000, 0, 0));
`ifdef LAMP_SQRT_DENORM_EN
        vecs.push_back(mk("sqrt_sub",   0, 16'h0001, 1, 2, 9'h100, 16'h2D41, 16'h1E35, 0, 0));
        vecs.push_back(mk("isq_sub",    1, 16'h0001, 1, 2, 9'h100, 16'h5A82, 16'h60B5, 0, 0));
        vecs.push_back(mk("neg_sub",    0, 16'h8001, 0, 0, 9'h000, 16'h0000, 16'h7FC0, 1, 0));
`else
        vecs.push_back(mk("sqrt_sub",   0, 16'h0001, 0, 0, 9'h000, 16'h0000, 16'h0000, 0, 0));
        vecs.push_back(mk("isq_sub",    1, 16'h0001, 0, 0, 9'h000, 16'h0000, 16'h7F80, 0, 1));
        vecs.push_back(mk("neg_sub",    0, 16'h8001, 0, 0, 9'h000, 16'h0000, 16'h8000, 0, 0));
`endif

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst valid", valid_o, 0);
        chk("rst result", result_o, 0);
        chk("rst f_o", f_o, 0);
        chk("rst launch", {doSqrt_o, doInvSqrt_o}, 0);
        chk("rst flags", {invalid_o, divzero_o}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst ready", ready_o, 1);

        // Spurious core strobe while idle
        fract_valid_i = 1'b1; fract_res_i = 16'h2000;
        @(negedge clk);
        fract_valid_i = 1'b0; fract_res_i = 16'hDEAD;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (valid_o || !ready_o) bad = 1;
        end
        chk("spurious_idle", bad, 0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // start_i held high through a whole operation
        @(negedge clk);
        start_i = 1'b1; op_i = 1'b0; op_a_i = 16'h4080;
        launches = 0; fed = 0; got = 0; cyc = 0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (doSqrt_o || doInvSqrt_o) launches++;
            if (fract_valid_i) begin
                fract_valid_i = 1'b0; fract_res_i = 16'hDEAD;
            end else if (launches == 1 && !fed && !(doSqrt_o || doInvSqrt_o)) begin
                fract_valid_i = 1'b1; fract_res_i = 16'h2000; fed = 1;
            end
            if (valid_o) begin
                got = 1;
                start_i = 1'b0;
                chk("held result", result_o, 16'h4000);
            end
        end
        start_i = 1'b0;
        chk("held done", got, 1);
        repeat (4) begin
            @(negedge clk);
            if (doSqrt_o || doInvSqrt_o || valid_o) launches++;
        end
        chk("held single", launches, 1);

        // Back-to-back: second op issued in the valid_o cycle
        @(negedge clk);
        start_i = 1'b1; op_i = 1'b0; op_a_i = 16'h4080;
        @(negedge clk);
        start_i = 1'b0;
        chk("b2b launch", doSqrt_o, 1);
        @(negedge clk);
        @(negedge clk);
        fract_valid_i = 1'b1; fract_res_i = 16'h2000;
        @(negedge clk);
        fract_valid_i = 1'b0; fract_res_i = 16'hDEAD;
        @(negedge clk);
        chk("b2b first valid", valid_o, 1);
        chk("b2b first result", result_o, 16'h4000);
        start_i = 1'b1; op_i = 1'b1; op_a_i = 16'h0000;
        @(negedge clk);
        start_i = 1'b0;
        chk("b2b gap", valid_o, 0);
        @(negedge clk);
        chk("b2b second valid", valid_o, 1);
        chk("b2b second result", result_o, 16'h7F80);
        chk("b2b second dz", divzero_o, 1);

        // Reset asserted while waiting for the core
        @(negedge clk);
        start_i = 1'b1; op_i = 1'b0; op_a_i = 16'h4080;
        @(negedge clk);
        start_i = 1'b0;
        chk("rstw launch", doSqrt_o, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstw result", result_o, 0);
        chk("rstw f_o", f_o, 0);
        chk("rstw valid", valid_o, 0);
        chk("rstw ready", ready_o, 1);
        @(negedge clk);
        rst = 1'b0;
        fract_valid_i = 1'b1; fract_res_i = 16'h2000;
        @(negedge clk);
        fract_valid_i = 1'b0; fract_res_i = 16'hDEAD;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (valid_o) bad = 1;
        end
        chk("rstw late_core", bad, 0);
        run_vec(vecs[2]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
